// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: FSM encoding, index width,
// vector table defaults and the vector address helper.
package interrupt_sequencer_pkg;

    localparam int IDX_W = 6;

    localparam logic [15:0]      VEC_BASE_DEF    = 16'hFF80;
    localparam logic [3:0]       VEC_TIMEOUT_DEF = 4'd15;
    localparam logic [IDX_W-1:0] NMI_INDEX       = 6'd62;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_ACK  = 2'd2,
        S_VEC  = 2'd3
    } state_t;

    // Vector entries are word aligned, so the index lands one bit up.
    function automatic logic [15:0] vec_addr_of(input logic [15:0] base,
                                                input logic [IDX_W-1:0] idx);
        return base | {{(15 - IDX_W){1'b0}}, idx, 1'b0};
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Chain-head and CPU-side signals of the interrupt sequencer.
// NMI exists only when INTSEQ_NMI_EN is defined.
interface interrupt_sequencer_if;
    import interrupt_sequencer_pkg::*;

    logic             GIE;
    logic             REQ_in;
    logic [IDX_W-1:0] IntAddr_in;
    logic             INTACK_out;
    logic             int_pending;
    logic             cpu_grant;
    logic             vec_valid;
    logic [15:0]      vec_addr;
    logic             vec_taken;
    logic             spurious;
    logic             vec_abort;
    logic             busy;
`ifdef INTSEQ_NMI_EN
    logic             NMI;
`endif

    modport master (
        input  GIE, REQ_in, IntAddr_in, cpu_grant, vec_taken,
`ifdef INTSEQ_NMI_EN
        input  NMI,
`endif
        output INTACK_out, int_pending, vec_valid, vec_addr,
               spurious, vec_abort, busy
    );

    modport slave (
        output GIE, REQ_in, IntAddr_in, cpu_grant, vec_taken,
`ifdef INTSEQ_NMI_EN
        output NMI,
`endif
        input  INTACK_out, int_pending, vec_valid, vec_addr,
               spurious, vec_abort, busy
    );

endinterface

// File: rtl/interrupt_sequencer.sv
// Hands the winning request of the interrupt priority chain to the CPU and
// presents its vector address. Optional NMI source: define INTSEQ_NMI_EN.
//
//   state  | meaning
//   IDLE   | no sequence; waiting for an enabled request (or NMI)
//   PEND   | int_pending raised, waiting for cpu_grant
//   ACK    | one cycle: INTACK into chain head, index latched
//   VEC    | vec_addr presented until vec_taken or timeout
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [15:0] VEC_BASE    = VEC_BASE_DEF,
    parameter logic [3:0]  VEC_TIMEOUT = VEC_TIMEOUT_DEF
) (
    input logic                   MCLK,
    input logic                   reset,
    interrupt_sequencer_if.master bus
);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [3:0]       tcnt;
    logic             spurious_q;
    logic             abort_q;
    logic             nmi_pend;
    logic             want;
    logic             expired;

`ifdef INTSEQ_NMI_EN
    logic nmi_q;

    // A pending NMI is consumed by whichever ACK cycle sees it.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            nmi_q    <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            nmi_q    <= bus.NMI;
            nmi_pend <= (nmi_pend && (state != S_ACK)) || (bus.NMI && !nmi_q);
        end
    end
`else
    assign nmi_pend = 1'b0;
`endif

    assign want    = nmi_pend || (bus.REQ_in && bus.GIE);
    assign expired = (tcnt == VEC_TIMEOUT);

    always_ff @(posedge MCLK) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (want) state_nx = S_PEND;
            S_PEND: begin
                if (!want)              state_nx = S_IDLE;
                else if (bus.cpu_grant) state_nx = S_ACK;
            end
            S_ACK:  state_nx = (nmi_pend || bus.REQ_in) ? S_VEC : S_IDLE;
            S_VEC:  if (bus.vec_taken || expired) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // tcnt counts VEC cycles from 1, so VEC_TIMEOUT is the number of cycles allowed.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            idx        <= '0;
            tcnt       <= '0;
            spurious_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            spurious_q <= (state == S_ACK) && !nmi_pend && !bus.REQ_in;
            abort_q    <= (state == S_VEC) && !bus.vec_taken && expired;
            if (state == S_ACK) begin
                idx  <= nmi_pend ? NMI_INDEX : bus.IntAddr_in;
                tcnt <= 4'd1;
            end else if ((state == S_VEC) && !expired) begin
                tcnt <= tcnt + 4'd1;
            end
        end
    end

    assign bus.int_pending = (state == S_PEND);
    assign bus.INTACK_out  = (state == S_ACK) && !nmi_pend;
    assign bus.vec_valid   = (state == S_VEC);
    assign bus.vec_addr    = (state == S_VEC) ? vec_addr_of(VEC_BASE, idx) : 16'h0000;
    assign bus.spurious    = spurious_q;
    assign bus.vec_abort   = abort_q;
    assign bus.busy        = (state != S_IDLE);

endmodule
